// File: rtl/gp_register_bank_pkg.sv
// Shared constants for the Mini SRC general-purpose register bank:
// IR field positions and the default datapath width.
package gp_register_bank_pkg;

    localparam int DATA_WIDTH_DEF = 32;

    localparam int RA_HI = 26;
    localparam int RA_LO = 23;
    localparam int RB_HI = 22;
    localparam int RB_LO = 19;
    localparam int RC_HI = 18;
    localparam int RC_LO = 15;
    localparam int C_HI  = 18;

    localparam int FIELD_WIDTH = RA_HI - RA_LO + 1;

endpackage

// File: rtl/gp_reg_cell.sv
// One bank register: asynchronous active-high clear to INIT, loads d_i when we_i is high.
module gp_reg_cell #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] INIT       = '0
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  we_i,
    input  logic [DATA_WIDTH-1:0] d_i,
    output logic [DATA_WIDTH-1:0] q_o
);

    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_d;

    assign data_d = we_i ? d_i : data_q;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            data_q <= INIT;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/gp_register_bank.sv
// Mini SRC register bank: IR field select, bus and link write arbitration,
// combinational read mux with R0-as-zero under baout, sticky written status.
module gp_register_bank
    import gp_register_bank_pkg::*;
#(
    parameter int                    DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int                    NUM_REGS   = 16,
    parameter int                    SEL_WIDTH  = 4,
    parameter int                    LINK_REG   = 15,
    parameter logic [DATA_WIDTH-1:0] INIT       = '0
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  enable,
    input  logic [31:0]           ir,
    input  logic                  gra,
    input  logic                  grb,
    input  logic                  grc,
    input  logic                  rin,
    input  logic                  rout,
    input  logic                  baout,
    input  logic [DATA_WIDTH-1:0] bus_mux_out,
    input  logic                  link_wr,
    input  logic [DATA_WIDTH-1:0] link_data,
    output logic [DATA_WIDTH-1:0] bus_mux_in,
    output logic                  read_valid,
    output logic [DATA_WIDTH-1:0] c_sext,
    output logic [NUM_REGS-1:0]   written_mask
);

    logic [FIELD_WIDTH-1:0] field;
    logic [SEL_WIDTH-1:0]   sel;
    logic [NUM_REGS-1:0]    we;
    logic [NUM_REGS-1:0]    mask_q;
    logic [NUM_REGS-1:0]    mask_d;
    logic [DATA_WIDTH-1:0]  reg_q [NUM_REGS];
    logic                   bus_wr;

    always_comb begin
        field = '0;
        if (gra) begin
            field = ir[RA_HI:RA_LO];
        end else if (grb) begin
            field = ir[RB_HI:RB_LO];
        end else if (grc) begin
            field = ir[RC_HI:RC_LO];
        end
    end

    // Upper field bits are dropped when the bank is smaller than 16 registers.
    assign sel    = field[SEL_WIDTH-1:0];
    assign bus_wr = enable && rin;

    genvar i;
    generate
        for (i = 0; i < NUM_REGS; i++) begin : g_cell
            logic is_link;
            logic bus_hit;
            logic [DATA_WIDTH-1:0] wdata;

            // The link path owns LINK_REG in a collision; the bus write is dropped.
            assign is_link = link_wr && (i == LINK_REG);
            assign bus_hit = bus_wr && (sel == SEL_WIDTH'(i));
            assign we[i]   = is_link || bus_hit;
            assign wdata   = is_link ? link_data : bus_mux_out;

            gp_reg_cell #(
                .DATA_WIDTH(DATA_WIDTH),
                .INIT      (INIT)
            ) u_cell (
                .clock(clock),
                .clear(clear),
                .we_i (we[i]),
                .d_i  (wdata),
                .q_o  (reg_q[i])
            );
        end
    endgenerate

    assign mask_d = mask_q | we;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end

    always_comb begin
        bus_mux_in = '0;
        if ((rout || baout) && !(baout && (sel == '0))) begin
            bus_mux_in = reg_q[sel];
        end
    end

    assign read_valid   = rout || baout;
    assign c_sext       = {{(DATA_WIDTH-C_HI-1){ir[C_HI]}}, ir[C_HI:0]};
    assign written_mask = mask_q;

    logic unused_ir;
    assign unused_ir = ^{ir[31:RA_HI+1], field};

endmodule

// File: tb/tb_gp_register_bank.sv
// Self-checking bench for gp_register_bank: directed scenarios plus random
// traffic compared against an array-based model of the register file.
module tb_gp_register_bank;

    localparam int DW = 32;
    localparam int NR = 16;
    localparam int LR = 15;

    logic          clock = 1'b0;
    logic          clear;
    logic          enable;
    logic [31:0]   ir;
    logic          gra, grb, grc, rin, rout, baout, link_wr;
    logic [DW-1:0] bus_mux_out;
    logic [DW-1:0] link_data;
    logic [DW-1:0] bus_mux_in;
    logic          read_valid;
    logic [DW-1:0] c_sext;
    logic [NR-1:0] written_mask;

    gp_register_bank dut (
        .clock       (clock),
        .clear       (clear),
        .enable      (enable),
        .ir          (ir),
        .gra         (gra),
        .grb         (grb),
        .grc         (grc),
        .rin         (rin),
        .rout        (rout),
        .baout       (baout),
        .bus_mux_out (bus_mux_out),
        .link_wr     (link_wr),
        .link_data   (link_data),
        .bus_mux_in  (bus_mux_in),
        .read_valid  (read_valid),
        .c_sext      (c_sext),
        .written_mask(written_mask)
    );

    // clock / reset
    always #5 clock = ~clock;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [DW-1:0] m_regs [NR];
    logic [NR-1:0] m_mask;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] last_bus;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // reference model
    task automatic model_reset();
        for (int k = 0; k < NR; k++) m_regs[k] = '0;
        m_mask = '0;
    endtask

    function automatic int model_sel(input logic a, input logic b, input logic c, input logic [31:0] irv);
        if (a) return int'(irv[26:23]);
        if (b) return int'(irv[22:19]);
        if (c) return int'(irv[18:15]);
        return 0;
    endfunction

    function automatic logic [DW-1:0] model_read();
        int s;
        s = model_sel(gra, grb, grc, ir);
        if (!(rout || baout)) return '0;
        if (baout && s == 0) return '0;
        return m_regs[s];
    endfunction

    function automatic logic [DW-1:0] model_sext(input logic [31:0] irv);
        logic [18:0] c;
        c = irv[18:0];
        return 32'(c) | (c[18] ? 32'hFFF8_0000 : 32'h0);
    endfunction

    task automatic model_write();
        int s;
        s = model_sel(gra, grb, grc, ir);
        if (enable && rin) begin
            m_regs[s] = bus_mux_out;
            m_mask[s] = 1'b1;
        end
        if (link_wr) begin
            m_regs[LR] = link_data;
            m_mask[LR] = 1'b1;
        end
    endtask

    // driver: called just after a rising edge; checks at the falling edge,
    // commits the model at the next rising edge.
    task automatic drive(input logic c, input logic en, input logic a, input logic b,
                         input logic cc, input logic ri, input logic ro, input logic ba,
                         input logic lw, input logic [31:0] irv, input logic [DW-1:0] bv,
                         input logic [DW-1:0] ld);
        clear = c; enable = en; gra = a; grb = b; grc = cc; rin = ri; rout = ro;
        baout = ba; link_wr = lw; ir = irv; bus_mux_out = bv; link_data = ld;
        if (c) model_reset();
        @(negedge clock);
        exp_q.push_back(model_read());
        last_bus = bus_mux_in;
        check("bus_mux_in", bus_mux_in, exp_q.pop_front());
        check("read_valid", 32'(read_valid), 32'(ro || ba));
        check("c_sext", c_sext, model_sext(irv));
        check("written_mask", 32'(written_mask), 32'(m_mask));
        @(posedge clock);
        if (!c) model_write();
        #1;
    endtask

    function automatic logic [31:0] ir_ra(input int r);
        return 32'(r) << 23;
    endfunction

    initial begin
        clear = 1'b1; enable = 0; gra = 0; grb = 0; grc = 0; rin = 0; rout = 0;
        baout = 0; link_wr = 0; ir = '0; bus_mux_out = '0; link_data = '0;
        model_reset();
        @(posedge clock); #1;

        // reset: read Ra=5 while clear is held
        drive(1, 0, 1, 0, 0, 0, 1, 0, 0, ir_ra(5), 32'h0, 32'h0);
        check("reset_read", last_bus, 32'h0);

        // write R3, read back R3 and R1
        drive(0, 1, 1, 0, 0, 1, 0, 0, 0, 32'h0188_0000, 32'hDEAD_BEEF, 32'h0);
        drive(0, 0, 1, 0, 0, 0, 1, 0, 0, 32'h0188_0000, 32'h0, 32'h0);
        check("r3_read", last_bus, 32'hDEAD_BEEF);
        check("mask_bit3", 32'(written_mask[3]), 32'h1);
        drive(0, 0, 0, 1, 0, 0, 1, 0, 0, 32'h0188_0000, 32'h0, 32'h0);
        check("r1_read", last_bus, 32'h0);

        // R0 under baout
        drive(0, 1, 1, 0, 0, 1, 0, 0, 0, ir_ra(0), 32'h1234, 32'h0);
        drive(0, 0, 1, 0, 0, 0, 1, 1, 0, ir_ra(0), 32'h0, 32'h0);
        check("r0_baout", last_bus, 32'h0);
        drive(0, 0, 1, 0, 0, 0, 1, 0, 0, ir_ra(0), 32'h0, 32'h0);
        check("r0_rout", last_bus, 32'h1234);

        // link collision on R15, then parallel link + bus write to R2
        drive(0, 1, 1, 0, 0, 1, 0, 0, 1, ir_ra(15), 32'h200, 32'h100);
        drive(0, 0, 1, 0, 0, 0, 1, 0, 0, ir_ra(15), 32'h0, 32'h0);
        check("r15_link_wins", last_bus, 32'h100);
        drive(0, 1, 1, 0, 0, 1, 0, 0, 1, ir_ra(2), 32'h222, 32'h333);
        drive(0, 0, 1, 0, 0, 0, 1, 0, 0, ir_ra(2), 32'h0, 32'h0);
        check("r2_parallel", last_bus, 32'h222);
        drive(0, 0, 1, 0, 0, 0, 1, 0, 0, ir_ra(15), 32'h0, 32'h0);
        check("r15_parallel", last_bus, 32'h333);

        // priority gra > grb > grc, and sign extension
        drive(0, 1, 1, 0, 0, 1, 0, 0, 0, ir_ra(7), 32'h7777, 32'h0);
        drive(0, 0, 1, 1, 1, 0, 1, 0, 0, ir_ra(7) | (32'h1 << 19) | (32'h2 << 15), 32'h0, 32'h0);
        check("priority_ra", last_bus, 32'h7777);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0004_0000, 32'h0, 32'h0);
        check("sext_neg", c_sext, 32'hFFFC_0000);

        // asynchronous clear mid-cycle
        drive(0, 1, 1, 0, 0, 1, 0, 0, 0, ir_ra(4), 32'hA5, 32'h0);
        clear = 0; enable = 0; rin = 0; gra = 1; rout = 1; ir = ir_ra(4);
        #2;
        check("r4_before_clear", bus_mux_in, 32'hA5);
        clear = 1'b1;
        #1;
        check("r4_async_clear", bus_mux_in, 32'h0);
        check("mask4_async_clear", 32'(written_mask[4]), 32'h0);
        model_reset();
        @(posedge clock); #1;
        clear = 1'b0;

        // random traffic
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 39) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 1), ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                  $urandom, $urandom, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/gp_register_bank.md
Name: gp_register_bank

Overview:
- Parametrised general-purpose register bank for the Mini SRC datapath. It replaces the individually instantiated R0..R15 registers and the separate select-and-encode logic.
- Decodes register fields from the IR and routes bus writes into the selected register.
- Drives the selected register onto the bus, with R0 forced to zero under BAout.
- Adds a dedicated link-register write path and a per-register "written" status vector.

Parameters:
- DATA_WIDTH, 32, width of every register and of the bus.
- NUM_REGS, 16, number of registers; must be a power of two, at most 16.
- SEL_WIDTH, 4, register index width; equals log2(NUM_REGS).
- LINK_REG, 15, index written by the link path.
- INIT, 0, value loaded into every register on reset.

Ports:
- clock, input, 1, system clock; all state updates on the rising edge.
- clear, input, 1, reset. One clock; reset is asynchronous and active-high.
- enable, input, 1, global write enable for the bus write path.
- ir, input, 32, instruction register contents. Ra = ir[26:23], Rb = ir[22:19], Rc = ir[18:15].
- gra, input, 1, select the Ra field.
- grb, input, 1, select the Rb field.
- grc, input, 1, select the Rc field.
- rin, input, 1, write bus_mux_out into the selected register.
- rout, input, 1, drive the selected register onto bus_mux_in.
- baout, input, 1, base-address read: as rout, but R0 reads as zero.
- bus_mux_out, input, DATA_WIDTH, write data from the bus.
- link_wr, input, 1, write link_data into LINK_REG.
- link_data, input, DATA_WIDTH, return address (PC) for the link write.
- bus_mux_in, output, DATA_WIDTH, read data toward the bus mux.
- read_valid, output, 1, high when rout or baout is asserted.
- c_sext, output, DATA_WIDTH, ir[18:0] sign-extended to DATA_WIDTH.
- written_mask, output, NUM_REGS, bit i is set once register i has been written since reset.

Behaviour:
- Reset (asynchronous, clear = 1): every register is set to INIT and written_mask is set to 0. While clear is high, all writes are ignored.
- Outputs during reset: bus_mux_in = 0 if neither rout nor baout is asserted, otherwise INIT.
- Select index:
  - Priority is gra > grb > grc.
  - If none of the three is asserted, sel = 0.
  - Only the low SEL_WIDTH bits of the chosen field are used; upper field bits are ignored when NUM_REGS < 16.
- Bus write: at posedge clock, if enable && rin && !clear, then reg[sel] <= bus_mux_out and written_mask[sel] <= 1. R0 is writable.
- Link write: at posedge clock, if link_wr && !clear, then reg[LINK_REG] <= link_data and written_mask[LINK_REG] <= 1. The link write is independent of enable.
- Write collision: if a bus write and a link write target LINK_REG in the same cycle, the link write wins and the bus write is dropped. A bus write to any other register proceeds in parallel with the link write.
- Read path is combinational, with zero added latency:
  - bus_mux_in = reg[sel] if (rout || baout), else 0.
  - If baout && sel == 0, then bus_mux_in = 0 regardless of rout.
  - read_valid = rout || baout.
- Read during write: a read in the same cycle returns the old value; the new value is visible after the edge.
- c_sext: combinational, {{(DATA_WIDTH-19){ir[18]}}, ir[18:0]}.
- written_mask bits are sticky; only clear resets them.
- Reset asserted mid-write: the asynchronous clear overrides, and the register holds INIT.

Decomposition:
- Shared package holds the IR field positions as constants: RA_HI/LO = 26/23, RB_HI/LO = 22/19, RC_HI/LO = 18/15, C_HI = 18.
- Shared package also holds the DATA_WIDTH default.
- One sub-module: gp_reg_cell, a single DATA_WIDTH register with asynchronous clear, INIT, write enable and data input. It is instantiated NUM_REGS times in a generate loop.
- Select decode, write arbitration and the read mux stay in the top level.

Test Plan:
- Reset: assert clear with INIT = 0. Then rout with gra and ir Ra = 5 -> bus_mux_in = 0, written_mask = 0.
- Write/read: ir = 0x01880000 (Ra = 3, Rb = 1, Rc = 0). Cycle 1: gra, rin, enable, bus = 0xDEADBEEF. Cycle 2: gra, rout -> bus_mux_in = 0xDEADBEEF, written_mask[3] = 1. Cycle 2 with grb, rout -> 0.
- R0 BAout: write 0x1234 to R0 (Ra = 0). Then baout with Ra = 0 -> bus_mux_in = 0. Then rout alone -> 0x1234.
- Link collision: in the same cycle, link_wr with link_data = 0x100, and rin/enable with Ra = 15, bus = 0x200 -> R15 = 0x100. Then link_wr with Ra = 2 targeted -> R2 and R15 both updated.
- Priority/sext: gra, grb and grc all high with Ra = 7 -> sel = 7. Set ir[18:0] = 0x40000 -> c_sext = 0xFFFC0000.
- Async clear: assert clear mid-cycle after R4 = 0xA5 -> R4 reads 0 immediately and written_mask[4] = 0 before the next edge.
